// File: rtl/cnn_cls_pkg.sv
// rtl/cnn_cls_pkg.sv - shared constants and types for the classifier score path
//
// Purpose: slot-order constants, FSM state enum, score and packed-vector types
// shared by class_score_packer and the downstream argmax stage.
package cnn_cls_pkg;

    localparam int NUM_CLASS = 10;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 32;
    localparam int OUT_W     = NUM_CLASS * DATA_W;
    localparam int CNT_W     = $clog2(NUM_CLASS);
    localparam int FCNT_W    = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    typedef logic signed [DATA_W-1:0] score_t;
    typedef logic [OUT_W-1:0]         packed_t;

endpackage

// File: rtl/class_score_packer_if.sv
// rtl/class_score_packer_if.sv - input score stream and packed frame output bundle
//
// Purpose: groups the accumulator input handshake and the packed-frame output
// handshake.
// Ports (slave = packer side):
//   in_valid/in_ready/in_psum/in_last  serial per-class accumulator beats
//   out_valid/out_ready/out_data       one packed frame of NUM_CLASS scores
interface class_score_packer_if
    import cnn_cls_pkg::*;
    ();

    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_psum;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_psum, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_psum, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/score_sat.sv
// rtl/score_sat.sv - arithmetic right shift then saturate to DATA_W signed
//
// Purpose: combinational rescale of one accumulator value into a score.
// Ports:
//   acc    in   ACC_W   signed accumulator
//   score  out  DATA_W  floor(acc / 2**FRAC_SHIFT) clamped to the DATA_W range
module score_sat #(
    parameter int ACC_W      = 32,
    parameter int DATA_W     = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] score
);

    // Range limits of the DATA_W result, expressed at ACC_W width.
    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC_SHIFT;
        if (shifted > MAX_V) begin
            score = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            score = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            score = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/class_score_packer.sv
// rtl/class_score_packer.sv - packs a frame of per-class scores for the argmax stage
//
// Purpose: accepts NUM_CLASS serial accumulator beats, rescales/saturates each
// into its 16-bit slot, then holds the packed frame until it is consumed.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   clear      synchronous frame abort (clears err_len, keeps data and count)
//   bus        class_score_packer_if slave (input stream + packed output)
//   frame_cnt  completed output handshakes, wrapping
//   err_len    sticky frame-length error
module class_score_packer
    import cnn_cls_pkg::*;
#(
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    class_score_packer_if.slave   bus,
    output logic [FCNT_W-1:0]     frame_cnt,
    output logic                  err_len
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                err_q, err_d;
    packed_t             out_data_q;
    score_t              score;
    logic                accept;
    logic                write_en;
    logic                last_beat;

    score_sat #(
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_score_sat (
        .acc   (bus.in_psum),
        .score (score)
    );

    // Handshake outputs decode state only, so out_ready never reaches in_ready.
    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_len       = err_q;

    assign accept    = bus.in_valid && (state_q == COLLECT);
    assign write_en  = accept && !clear;
    assign last_beat = (cnt_q == CNT_W'(NUM_CLASS - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        if (clear) begin
            state_d = COLLECT;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (last_beat) begin
                            // Frame completes even if in_last is missing.
                            cnt_d   = '0;
                            state_d = HOLD;
                            if (!bus.in_last) begin
                                err_d = 1'b1;
                            end
                        end else if (bus.in_last) begin
                            // Short frame: drop it and restart at slot 0.
                            cnt_d = '0;
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = COLLECT;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // Each accepted beat lands in the slot selected by the beat count;
    // slots not written this frame keep their previous contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                if (write_en && (cnt_q == CNT_W'(k))) begin
                    out_data_q[k*DATA_W +: DATA_W] <= score;
                end
            end
        end
    end

endmodule

// File: tb/tb_class_score_packer.sv
// tb/tb_class_score_packer.sv - directed self-checking bench for class_score_packer
module tb_class_score_packer;
    import cnn_cls_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] frame_cnt;
    logic        err_len;

    class_score_packer_if bus ();

    class_score_packer #(.FRAC_SHIFT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  beats [10];
    logic [15:0]  exp_slot [10];
    logic [159:0] exp_data;
    logic [15:0]  exp_fc = 16'd0;

    task automatic send_beats(input int first, input int count, input int last_idx);
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_psum  = beats[i];
            bus.in_last  = (i == last_idx);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_psum  = '0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic build_exp();
        for (int i = 0; i < 10; i++) exp_data[i*16 +: 16] = exp_slot[i];
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_psum = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err_len} !== 3'b010) begin
            n_fail++; $display("FAIL reset_flags: got valid/ready/err=%b want 010", {bus.out_valid, bus.in_ready, err_len});
        end
        n_checks++;
        if (bus.out_data !== 160'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_checks++;
        if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    endtask

    task automatic test_full_rate();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin beats[i] = 32'h100 * (i + 1); exp_slot[i] = 16'(i + 1); end
        build_exp();
        send_beats(0, 9, 9);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL full_before_last: got valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
        end
        send_beats(9, 1, 9);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency: got out_valid=%b want 1", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL full_data: got %h want %h", bus.out_data, exp_data); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_fc = 16'd1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, frame_cnt} !== {2'b01, exp_fc}) begin
            n_fail++; $display("FAIL full_handshake: got valid/ready=%b fcnt=%0d want 01 fcnt=%0d", {bus.out_valid, bus.in_ready}, frame_cnt, exp_fc);
        end
    endtask

    task automatic test_saturation();
        beats = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFE80, 32'hFFFFFFFF, 32'h007FFF00,
                  32'h00800000, 32'hFF800000, 32'hFF7FFFFF, 32'h000000FF, 32'hFFFFFF01};
        exp_slot = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'hFFFF, 16'h7FFF,
                     16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
        send_beats(0, 10, 9);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.out_data[i*16 +: 16] !== exp_slot[i]) begin
                n_fail++; $display("FAIL sat_slot%0d: got %h want %h (psum %h)", i + 1, bus.out_data[i*16 +: 16], exp_slot[i], beats[i]);
            end
        end
        pop();
        exp_fc++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin beats[i] = 32'h100 * (i + 21); exp_slot[i] = 16'(i + 21); end
        build_exp();
        send_beats(0, 10, 9);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== {2'b01, exp_data}) begin
                n_fail++; $display("FAIL bp_hold_c%0d: got ready/valid=%b data=%h want 01 %h", c, {bus.in_ready, bus.out_valid}, bus.out_data, exp_data);
            end
            bus.in_valid = 1'b1; bus.in_psum = 32'h12345678; bus.in_last = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        pop();
        exp_fc++;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err_len, frame_cnt} !== {3'b010, exp_fc}) begin
            n_fail++; $display("FAIL bp_release: got valid/ready/err=%b fcnt=%0d want 010 fcnt=%0d", {bus.out_valid, bus.in_ready, err_len}, frame_cnt, exp_fc);
        end
        for (int i = 0; i < 10; i++) begin beats[i] = 32'h300 * (i + 1); exp_slot[i] = 16'(3 * (i + 1)); end
        build_exp();
        send_beats(0, 10, 9);
        n_checks++;
        if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL bp_next_frame: got %h want %h", bus.out_data, exp_data); end
        pop();
        exp_fc++;
    endtask

    task automatic test_frame_len();
        for (int i = 0; i < 10; i++) beats[i] = 32'h100 * (i + 1) + 32'h55;
        send_beats(0, 4, 3);
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err_len} !== 3'b011) begin
            n_fail++; $display("FAIL early_last: got valid/ready/err=%b want 011", {bus.out_valid, bus.in_ready, err_len});
        end
        for (int i = 0; i < 10; i++) begin beats[i] = 32'h200 * (i + 1); exp_slot[i] = 16'(2 * (i + 1)); end
        build_exp();
        send_beats(0, 10, 9);
        n_checks++;
        if ({bus.out_valid, err_len, bus.out_data} !== {2'b11, exp_data}) begin
            n_fail++; $display("FAIL after_early: got valid/err=%b data=%h want 11 %h", {bus.out_valid, err_len}, bus.out_data, exp_data);
        end
        pop();
        exp_fc++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if ({err_len, frame_cnt, bus.out_data} !== {1'b0, exp_fc, exp_data}) begin
            n_fail++; $display("FAIL clear_keep: got err=%b fcnt=%0d data=%h want 0 %0d %h", err_len, frame_cnt, bus.out_data, exp_fc, exp_data);
        end
        send_beats(0, 10, -1);
        n_checks++;
        if ({bus.out_valid, err_len} !== 2'b11) begin
            n_fail++; $display("FAIL missing_last: got valid/err=%b want 11", {bus.out_valid, err_len});
        end
        clear = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, err_len, frame_cnt} !== {3'b010, exp_fc}) begin
            n_fail++; $display("FAIL clear_over_hs: got valid/ready/err=%b fcnt=%0d want 010 fcnt=%0d", {bus.out_valid, bus.in_ready, err_len}, frame_cnt, exp_fc);
        end
        send_beats(0, 5, -1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin beats[i] = 32'h700 * (i + 1); exp_slot[i] = 16'(7 * (i + 1)); end
        build_exp();
        send_beats(0, 10, 9);
        n_checks++;
        if ({bus.out_valid, err_len, bus.out_data} !== {2'b10, exp_data}) begin
            n_fail++; $display("FAIL clear_midframe: got valid/err=%b data=%h want 10 %h", {bus.out_valid, err_len}, bus.out_data, exp_data);
        end
        pop();
        exp_fc++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) beats[i] = 32'h100 * (i + 1);
        send_beats(0, 6, -1);
        rst = 1'b0;
        #1;
        exp_fc = 16'd0;
        n_checks++;
        if ({bus.out_valid, frame_cnt} !== {1'b0, exp_fc}) begin
            n_fail++; $display("FAIL rst_midframe: got valid=%b fcnt=%0d want 0 0", bus.out_valid, frame_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin beats[i] = 32'hB00 * (i + 1); exp_slot[i] = 16'(11 * (i + 1)); end
        build_exp();
        send_beats(0, 10, 9);
        n_checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, exp_data}) begin
            n_fail++; $display("FAIL rst_next_frame: got valid=%b data=%h want 1 %h", bus.out_valid, bus.out_data, exp_data);
        end
        pop();
        for (int i = 0; i < 10; i++) beats[i] = 32'h100 * (i + 1);
        send_beats(0, 10, 9);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, frame_cnt, bus.out_data} !== {2'b01, 16'd0, 160'd0}) begin
            n_fail++; $display("FAIL rst_hold: got valid/ready=%b fcnt=%0d data=%h want 01 0 0", {bus.out_valid, bus.in_ready}, frame_cnt, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin beats[i] = 32'hD00 * (i + 1); exp_slot[i] = 16'(13 * (i + 1)); end
        build_exp();
        send_beats(0, 10, 9);
        n_checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, exp_data}) begin
            n_fail++; $display("FAIL rst_hold_next: got valid=%b data=%h want 1 %h", bus.out_valid, bus.out_data, exp_data);
        end
        pop();
        exp_fc = 16'd1;
        n_checks++;
        if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rst_fcnt_restart: got %0d want %0d", frame_cnt, exp_fc); end
    endtask

    task automatic test_frame_cnt_wrap();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        n_checks++;
        if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
        send_beats(0, 10, 9);
        pop();
        n_checks++;
        if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h want 0000", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_saturation();
        test_backpressure();
        test_frame_len();
        test_reset_mid();
        test_frame_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
